// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared command codes, state encoding and helpers for the JK bank sequencer
package jk_seq_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// rtl/jk_bank_sequencer_if.sv - requester-side bus of the JK bank sequencer
interface jk_bank_sequencer_if #(
  parameter int NBITS = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = 3
);

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic                 err;
  logic                 busy;
  logic [NBITS-1:0]     q_bank;

  modport master (
    output req, req_cmd, req_idx,
    input  gnt, done, err, busy, q_bank
  );

  modport slave (
    input  req, req_cmd, req_idx,
    output gnt, done, err, busy, q_bank
  );

endinterface

// File: rtl/JK_FlipFlop.sv
// rtl/JK_FlipFlop.sv - single JK flip-flop cell: 00 hold, 01 clear, 10 set, 11 toggle
module JK_FlipFlop (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or above ptr, with wrap
module rr_arbiter
  import jk_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PTRW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [PTRW-1:0] win_idx,
  output logic            win_valid
);

  int cand;

  // Scan from the farthest offset down so the nearest request to ptr is the last one kept.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand       = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (req[cand]) begin
        win_onehot       = '0;
        win_onehot[cand] = 1'b1;
        win_idx          = PTRW'(cand);
        win_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - round-robin shared access to a bank of JK flip-flops, one command per two cycles
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_sequencer_if.slave  bus
);

  localparam int PTRW = ptr_width(NREQ);

  state_e            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   win_q, win_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   arb_onehot;
  logic [PTRW-1:0]   arb_idx;
  logic              arb_valid;
  int                arb_i;

  logic              idx_ok;
  logic [1:0]        cmd_eff;
  logic [NBITS-1:0]  j_vec, k_vec, q_vec;

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_arb (
    .req        (bus.req),
    .ptr        (ptr_q),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .win_valid  (arb_valid)
  );

  assign idx_ok  = (int'(idx_q) < NBITS);
  assign cmd_eff = idx_ok ? cmd_q : CMD_HOLD;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    arb_i   = int'(arb_idx);
    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_APPLY;
          gnt_d   = arb_onehot;
          win_d   = arb_idx;
          cmd_d   = bus.req_cmd[2*arb_i +: 2];
          idx_d   = bus.req_idx[IDXW*arb_i +: IDXW];
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = ~idx_ok;
        ptr_d   = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + PTRW'(1);
      end
      default: state_d = ST_CLEAR;
    endcase
    // Reset discards any in-flight op; the bank drive below still follows state_q this edge.
    if (rst) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      win_d   = '0;
      cmd_d   = CMD_HOLD;
      idx_d   = '0;
      gnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    win_q   <= win_d;
    cmd_q   <= cmd_d;
    idx_q   <= idx_d;
    gnt_q   <= gnt_d;
    done_q  <= done_d;
    err_q   <= err_d;
    busy_q  <= busy_d;
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    case (state_q)
      ST_CLEAR: k_vec = '1;
      ST_APPLY: begin
        for (int i = 0; i < NBITS; i++) begin
          if (int'(idx_q) == i) begin
            j_vec[i] = cmd_eff[1];
            k_vec[i] = cmd_eff[0];
          end
        end
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_bank
    JK_FlipFlop u_cell (
      .clk (clk),
      .j   (j_vec[gi]),
      .k   (k_vec[gi]),
      .q   (q_vec[gi])
    );
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.q_bank = q_vec;

endmodule
